spi_slave_frontend: RTL and testbench



---
 rtl/spi_ram_pkg.sv | 21 ++
 rtl/spi_piso_shifter.sv | 64 ++++++
 rtl/spi_slave_frontend.sv | 120 ++++++++++++
 tb/tb_spi_slave_frontend.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI-to-RAM wrapper: FSM states,
// command encodings and the frame/response widths.
package spi_ram_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

endpackage

// File: rtl/spi_piso_shifter.sv
// Parallel-in/serial-out shifter, MSB first. With SPI_MISO_PARITY_EN defined
// an even-parity bit follows the data bits; otherwise only the data is sent.
module spi_piso_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_serial
);

`ifdef SPI_MISO_PARITY_EN
    localparam int TAIL_BITS = DATA_W;
`else
    localparam int TAIL_BITS = DATA_W - 1;
`endif
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_sreg;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out;
    logic              r_busy;
    logic              w_tail;

    // The parity bit rides in the LSB so it falls out right after data bit 0.
`ifdef SPI_MISO_PARITY_EN
    assign w_tail = ^i_data;
`else
    assign w_tail = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_out  <= 1'b0;
            r_busy <= 1'b0;
        end else if (i_clear) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_out  <= 1'b0;
            r_busy <= 1'b0;
        end else if (i_load) begin
            r_out  <= i_data[DATA_W-1];
            r_sreg <= {i_data[DATA_W-2:0], w_tail};
            r_cnt  <= CNT_W'(TAIL_BITS);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt != '0) begin
                r_out  <= r_sreg[DATA_W-1];
                r_sreg <= {r_sreg[DATA_W-2:0], 1'b0};
                r_cnt  <= r_cnt - 1'b1;
            end else begin
                r_out  <= 1'b0;
                r_busy <= 1'b0;
            end
        end
    end

    assign o_serial = r_out;

endmodule

// File: rtl/spi_slave_frontend.sv
// SPI slave in front of the wrapper RAM: deserializes 10-bit command frames
// and serializes read data onto MISO (parity bit when SPI_MISO_PARITY_EN).
module spi_slave_frontend #(
    parameter int CMD_W  = spi_ram_pkg::CMD_W,
    parameter int DATA_W = spi_ram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [CMD_W-1:0]  rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);
    import spi_ram_pkg::*;

    localparam logic [3:0] FRAME_BITS = 4'(CMD_W);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_cnt;
    logic [CMD_W-2:0] r_shift;
    logic [CMD_W-1:0] r_rx_data;
    logic             r_rx_valid;
    logic             r_rd_addr_seen;
    logic             r_resp_taken;
    logic             w_in_frame;
    logic             w_sample;
    logic             w_last;
    logic             w_load;

    assign w_in_frame = (r_state == WRITE) || (r_state == READ_ADD) ||
                        (r_state == READ_DATA);
    assign w_sample   = !SS_n && ((r_state == CHK_CMD) ||
                                  (w_in_frame && (r_cnt < FRAME_BITS)));
    assign w_last     = w_sample && w_in_frame && (r_cnt == FRAME_BITS - 4'd1);
    // A full frame has been counted once r_cnt reaches FRAME_BITS; only then
    // does a read-data frame listen for the RAM response, and only once.
    assign w_load     = !SS_n && (r_state == READ_DATA) && (r_cnt == FRAME_BITS) &&
                        !r_resp_taken && tx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (!SS_n) w_next = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)                w_next = IDLE;
                else if (!MOSI)          w_next = WRITE;
                else if (r_rd_addr_seen) w_next = READ_DATA;
                else                     w_next = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_shift        <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rd_addr_seen <= 1'b0;
            r_resp_taken   <= 1'b0;
        end else begin
            r_rx_valid <= w_last;
            if (w_last) begin
                r_rx_data <= {r_shift, MOSI};
            end
            if (w_sample) begin
                r_shift <= {r_shift[CMD_W-3:0], MOSI};
            end
            if (SS_n) begin
                r_cnt        <= '0;
                r_resp_taken <= 1'b0;
            end else begin
                if (w_sample && (r_cnt != 4'hF)) begin
                    r_cnt <= r_cnt + 4'd1;
                end
                if (w_load) begin
                    r_resp_taken <= 1'b1;
                end
            end
            // Only a completed frame may change the read-pair tracking.
            if (w_last) begin
                if (r_state == READ_ADD)       r_rd_addr_seen <= 1'b1;
                else if (r_state == READ_DATA) r_rd_addr_seen <= 1'b0;
            end
        end
    end

    spi_piso_shifter #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (SS_n),
        .i_load   (w_load),
        .i_data   (tx_data),
        .o_serial (MISO)
    );

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_frontend.sv
// Directed self-checking bench for spi_slave_frontend; expected MISO tails
// depend on SPI_MISO_PARITY_EN.
module tb_spi_slave_frontend;
    import spi_ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    int errors = 0;
    int checks = 0;

    spi_slave_frontend #(
        .CMD_W  (10),
        .DATA_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    // Drives SS_n low then the 10 frame bits; lat is the number of posedges
    // from the first SS_n-low edge (inclusive) up to the first rx_valid seen.
    task automatic drive_frame(input logic [9:0] f, output int lat,
                               output logic [9:0] data, output int pulses);
        int n;
        lat = -1; data = 10'h000; pulses = 0; n = 0;
        @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk); n++;
            if (rx_valid) begin
                pulses++;
                if (lat < 0) begin lat = n; data = rx_data; end
            end
            MOSI = f[i];
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); n++;
            if (rx_valid) begin
                pulses++;
                if (lat < 0) begin lat = n; data = rx_data; end
            end
        end
        MOSI = 1'b0;
    endtask

    task automatic end_frame();
        @(negedge clk); SS_n = 1'b1;
        @(negedge clk);
    endtask

    // bits[9] is the MISO value in the cycle right after the tx_valid cycle.
    task automatic tx_capture(input logic [7:0] d, output logic [9:0] bits);
        @(negedge clk); tx_valid = 1'b1; tx_data = d;
        @(negedge clk); tx_valid = 1'b0; bits[9] = MISO;
        for (int i = 8; i >= 0; i--) begin
            @(negedge clk); bits[i] = MISO;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got=%b want=0", MISO); end
        checks++; if (rx_data !== 10'h000) begin errors++; $display("FAIL reset_rx_data got=%h want=000", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_frame();
        int lat, pulses;
        logic [9:0] data;
        drive_frame(10'h0A5, lat, data, pulses);
        checks++; if (lat != 11) begin errors++; $display("FAIL wr_latency got=%0d want=11", lat); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL wr_pulses got=%0d want=1", pulses); end
        checks++; if (data !== 10'h0A5) begin errors++; $display("FAIL wr_rx_data got=%h want=0a5", data); end
        end_frame();
        repeat (2) @(negedge clk);
        checks++; if (rx_data !== 10'h0A5) begin errors++; $display("FAIL rx_data_hold got=%h want=0a5", rx_data); end
    endtask

    task automatic test_reset_mid_frame();
        int lat, pulses;
        logic [9:0] data;
        logic [9:0] f;
        f = 10'h2FF;
        @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
        for (int i = 9; i >= 5; i--) begin
            @(negedge clk); MOSI = f[i];
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rx_data !== 10'h000) begin errors++; $display("FAIL midrst_rx_data got=%h want=000", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_rx_valid got=%b want=0", rx_valid); end
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL midrst_miso got=%b want=0", MISO); end
        SS_n = 1'b1; MOSI = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        drive_frame(10'h17E, lat, data, pulses);
        checks++; if (data !== 10'h17E) begin errors++; $display("FAIL midrst_next_data got=%h want=17e", data); end
        checks++; if (lat != 11 || pulses != 1) begin errors++; $display("FAIL midrst_next_timing got=lat%0d/p%0d want=lat11/p1", lat, pulses); end
        end_frame();
    endtask

    task automatic test_read_pair();
        int lat, pulses;
        logic [9:0] data;
        logic [9:0] bits;
        drive_frame(10'h23C, lat, data, pulses);
        checks++; if (data !== 10'h23C || pulses != 1) begin errors++; $display("FAIL rdaddr_frame got=%h/p%0d want=23c/p1", data, pulses); end
        end_frame();
        drive_frame(10'h300, lat, data, pulses);
        checks++; if (data !== 10'h300 || pulses != 1) begin errors++; $display("FAIL rddata_frame got=%h/p%0d want=300/p1", data, pulses); end
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL rd_miso_idle got=%b want=0", MISO); end
        tx_capture(8'hC3, bits);
        // 0xC3 has four ones, so the parity bit (when present) is 0 as well.
        checks++; if (bits !== 10'b11000011_00) begin errors++; $display("FAIL rd_miso_c3 got=%b want=1100001100", bits); end
        tx_capture(8'h5A, bits);
        checks++; if (bits !== 10'b0) begin errors++; $display("FAIL rd_second_txvalid got=%b want=0000000000", bits); end
        end_frame();
    endtask

    task automatic test_unpaired_read();
        int lat, pulses;
        logic [9:0] data;
        logic [9:0] bits;
        drive_frame(10'h355, lat, data, pulses);
        checks++; if (data !== 10'h355 || pulses != 1) begin errors++; $display("FAIL unpaired_frame got=%h/p%0d want=355/p1", data, pulses); end
        tx_capture(8'hFF, bits);
        checks++; if (bits !== 10'b0) begin errors++; $display("FAIL unpaired_no_resp got=%b want=0000000000", bits); end
        end_frame();
    endtask

    task automatic test_abort();
        int lat, pulses;
        logic [9:0] data;
        logic [9:0] bits;
        logic [9:0] f;
        int aborted;
        f = 10'h3C3;
        aborted = 0;
        @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
        for (int i = 9; i >= 4; i--) begin
            @(negedge clk); if (rx_valid) aborted++;
            MOSI = f[i];
        end
        @(negedge clk); if (rx_valid) aborted++;
        SS_n = 1'b1; MOSI = 1'b0;
        @(negedge clk); if (rx_valid) aborted++;
        checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL abort_idle got=%0d want=%0d", dut.r_state, IDLE); end
        repeat (6) begin @(negedge clk); if (rx_valid) aborted++; end
        checks++; if (aborted != 0) begin errors++; $display("FAIL abort_no_rx_valid got=%0d want=0", aborted); end
        // rd_addr_seen is still set from the unpaired frame, so this is a read-data frame.
        drive_frame(10'h300, lat, data, pulses);
        checks++; if (data !== 10'h300) begin errors++; $display("FAIL abort_next_frame got=%h want=300", data); end
        tx_capture(8'hA1, bits);
`ifdef SPI_MISO_PARITY_EN
        checks++; if (bits !== 10'b10100001_10) begin errors++; $display("FAIL abort_miso_a1 got=%b want=1010000110", bits); end
`else
        checks++; if (bits !== 10'b10100001_00) begin errors++; $display("FAIL abort_miso_a1 got=%b want=1010000100", bits); end
`endif
        end_frame();
    endtask

    task automatic test_tx_in_write();
        int lat, pulses;
        logic [9:0] data;
        logic [9:0] bits;
        drive_frame(10'h012, lat, data, pulses);
        checks++; if (data !== 10'h012 || pulses != 1) begin errors++; $display("FAIL wr2_frame got=%h/p%0d want=012/p1", data, pulses); end
        tx_capture(8'hFF, bits);
        checks++; if (bits !== 10'b0) begin errors++; $display("FAIL wr_txvalid_ignored got=%b want=0000000000", bits); end
        end_frame();
    endtask

    initial begin
        test_reset();
        test_write_frame();
        test_reset_mid_frame();
        test_read_pair();
        test_unpaired_read();
        test_abort();
        test_tx_in_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
